ws2812_frame_tx: RTL and testbench



---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/ws2812_bit_encoder.sv | 69 ++++++
 rtl/ws2812_frame_tx.sv | 118 +++++++++++
 tb/tb_ws2812_frame_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame transmitter.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StLatch
    } state_e;

    localparam int unsigned DefaultNumBytes   = 16;
    localparam int unsigned DefaultT0h        = 20;
    localparam int unsigned DefaultT1h        = 40;
    localparam int unsigned DefaultBitCycles  = 63;
    localparam int unsigned DefaultResetCycles = 3000;

    function automatic int unsigned frame_bits(input int unsigned num_bytes);
        return 8 * num_bytes;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one NRZ pulse-width encoded bit period; a go in the bit_done cycle chains
// the next bit with no gap.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H        = DefaultT0h,
    parameter int unsigned T1H        = DefaultT1h,
    parameter int unsigned BIT_CYCLES = DefaultBitCycles
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_i,
    input  logic bit_i,
    output logic wave_o,
    output logic high_end_o,
    output logic bit_done_o
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);
    localparam logic [CntW-1:0] T0hC    = CntW'(T0H);
    localparam logic [CntW-1:0] T1hC    = CntW'(T1H);
    localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

    logic            active_q, active_d;
    logic            val_q, val_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wave_q, wave_d;
    logic [CntW-1:0] high_len;

    always_comb begin
        active_d   = active_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        high_len   = val_q ? T1hC : T0hC;
        high_end_o = active_q && (cnt_q == high_len - 1'b1);
        bit_done_o = active_q && (cnt_q == LastCnt);

        if (go_i) begin
            active_d = 1'b1;
            val_d    = bit_i;
            cnt_d    = '0;
        end else if (bit_done_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Waveform is registered, so it is computed from the next-state phase.
        wave_d = active_d && (cnt_d < (val_d ? T1hC : T0hC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            val_q    <= 1'b0;
            cnt_q    <= '0;
            wave_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            val_q    <= val_d;
            cnt_q    <= cnt_d;
            wave_q   <= wave_d;
        end
    end

    assign wave_o = wave_q;

endmodule

// File: rtl/ws2812_frame_tx.sv
// Snapshots the LED data bank on start, serialises it MSB-first byte 0 upward onto the
// WS2812 line, then holds the latch interval and pulses done.
module ws2812_frame_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_BYTES    = DefaultNumBytes,
    parameter int unsigned T0H          = DefaultT0h,
    parameter int unsigned T1H          = DefaultT1h,
    parameter int unsigned BIT_CYCLES   = DefaultBitCycles,
    parameter int unsigned RESET_CYCLES = DefaultResetCycles
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_BYTES-1:0] frame_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   dout
);

    localparam int unsigned FrameBits = frame_bits(NUM_BYTES);
    localparam int unsigned IdxW      = $clog2(FrameBits);
    localparam int unsigned LatchW    = $clog2(RESET_CYCLES + 1);
    localparam logic [IdxW-1:0]   LastIdx   = IdxW'(FrameBits - 1);
    localparam logic [LatchW-1:0] LatchLast = LatchW'(RESET_CYCLES - 1);

    state_e               state_q, state_d;
    logic [FrameBits-1:0] shadow_q, shadow_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [IdxW-1:0]      idx_next;
    logic [LatchW-1:0]    latch_q, latch_d;
    logic                 done_q, done_d;
    logic                 enc_go, enc_bit, enc_high_end, enc_bit_done;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        latch_d  = latch_q;
        done_d   = 1'b0;
        enc_go   = 1'b0;
        enc_bit  = 1'b0;
        idx_next = idx_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = frame_in;
                    idx_d    = '0;
                    latch_d  = '0;
                    enc_go   = 1'b1;
                    enc_bit  = frame_in[7];
                    state_d  = StHigh;
                end
            end
            StHigh: begin
                if (enc_high_end) state_d = StLow;
            end
            StLow: begin
                if (enc_bit_done) begin
                    if (idx_q == LastIdx) begin
                        latch_d = '0;
                        state_d = StLatch;
                    end else begin
                        idx_d   = idx_next;
                        enc_go  = 1'b1;
                        // Flipping the low three index bits walks each byte MSB first.
                        enc_bit = shadow_q[idx_next ^ IdxW'(7)];
                        state_d = StHigh;
                    end
                end
            end
            StLatch: begin
                if (latch_q == LatchLast) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    latch_d = latch_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            idx_q    <= '0;
            latch_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
            done_q   <= done_d;
        end
    end

    ws2812_bit_encoder #(
        .T0H        (T0H),
        .T1H        (T1H),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_encoder (
        .clk        (clk),
        .rst_n      (rst_n),
        .go_i       (enc_go),
        .bit_i      (enc_bit),
        .wave_o     (dout),
        .high_end_o (enc_high_end),
        .bit_done_o (enc_bit_done)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Randomised self-checking bench for ws2812_frame_tx against a cycle-offset waveform model.
module tb_ws2812_frame_tx;

    localparam int NB    = 16;
    localparam int T0    = 20;
    localparam int T1    = 40;
    localparam int BC    = 63;
    localparam int RC    = 3000;
    localparam int FB    = 8 * NB;
    localparam int BITS_END = FB * BC;
    localparam int TOTAL = BITS_END + RC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [FB-1:0] frame_in = '0;
    logic          busy, done, dout;

    int n_checks = 0;
    int n_errors = 0;
    bit wave [0:TOTAL];

    ws2812_frame_tx #(
        .NUM_BYTES    (NB),
        .T0H          (T0),
        .T1H          (T1),
        .BIT_CYCLES   (BC),
        .RESET_CYCLES (RC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frame_in (frame_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected line level t cycles after the accepting start edge.
    function automatic bit model_dout(input logic [FB-1:0] data, input int t);
        int b, k, ph;
        bit v;
        if (t >= BITS_END) return 1'b0;
        b  = t / BC;
        ph = t % BC;
        k  = b / 8;
        v  = data[8 * k + (7 - b % 8)];
        return ph < (v ? T1 : T0);
    endfunction

    function automatic int ones_in(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i < hi; i++) n += int'(wave[i]);
        return n;
    endfunction

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] d;
        for (int i = 0; i < FB / 32; i++) d[32 * i +: 32] = $urandom;
        return d;
    endfunction

    task automatic run_frame(input string tag, input logic [FB-1:0] data, input bit prestarted,
                             input bit mutate, input bit spurious, input bit chain);
        int e_dout = 0;
        int e_busy = 0;
        int e_done = 0;
        int first_rise = -1;
        frame_in = data;
        if (!prestarted) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t <= TOTAL; t++) begin
            @(negedge clk);
            wave[t] = dout;
            if (dout !== model_dout(data, t)) e_dout++;
            if (busy !== (t < TOTAL)) e_busy++;
            if (done !== (t == TOTAL)) e_done++;
            if (first_rise < 0 && dout === 1'b1) first_rise = t;
            if (mutate && t == 3000) frame_in = '1;
            if (spurious) start = (t == 100 || t == 5000);
            if (chain && t == TOTAL) start = 1'b1;
        end
        check_eq({tag, "_dout_errs"}, e_dout, 0);
        check_eq({tag, "_busy_errs"}, e_busy, 0);
        check_eq({tag, "_done_errs"}, e_done, 0);
        check_eq({tag, "_first_rise"}, first_rise, 0);
        check_eq({tag, "_latch_ones"}, ones_in(BITS_END, TOTAL + 1), 0);
    endtask

    task automatic abort_at(input string tag, input int t_abort, input int exp_dout);
        int viol = 0;
        frame_in = rand_frame();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t <= t_abort; t++) @(negedge clk);
        check_eq({tag, "_busy_before"}, int'(busy), 1);
        check_eq({tag, "_dout_before"}, int'(dout), exp_dout);
        #2 rst_n = 1'b0;
        #1;
        check_eq({tag, "_dout_in_rst"}, int'(dout), 0);
        check_eq({tag, "_busy_in_rst"}, int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        check_eq({tag, "_quiet_after"}, viol, 0);
    endtask

    initial begin
        int viol;
        logic [FB-1:0] d;

        // Reset held with start asserted, then idle with start low.
        rst_n = 1'b0;
        start = 1'b1;
        viol  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        check_eq("reset_hold", viol, 0);
        start = 1'b0;
        rst_n = 1'b1;
        viol  = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        check_eq("idle_quiet", viol, 0);

        // Byte 0 = 0x80: only the very first bit is a '1'.
        d = '0;
        d[7] = 1'b1;
        run_frame("first_bit", d, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("bit0_high", ones_in(0, BC), 40);
        check_eq("bit1_high", ones_in(BC, 2 * BC), 20);

        // Byte 15 = 0x01 with frame_in overwritten mid-frame.
        d = '0;
        d[FB - 8] = 1'b1;
        run_frame("last_bit", d, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("bit127_high", ones_in(127 * BC, 128 * BC), 40);
        check_eq("bit126_high", ones_in(126 * BC, 127 * BC), 20);

        // Spurious starts while busy, then start on the done cycle chains a frame.
        run_frame("spurious", rand_frame(), 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("chain_gap_low", (TOTAL + 1 - BITS_END) - ones_in(BITS_END, TOTAL + 1), RC + 1);
        run_frame("chained", rand_frame(), 1'b1, 1'b0, 1'b0, 1'b0);
        viol = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        check_eq("no_extra_frame", viol, 0);

        // Asynchronous aborts mid-bit (during the high phase) and mid-latch.
        abort_at("abort_bit50", 50 * BC + 5, 1);
        abort_at("abort_latch", BITS_END + 100, 0);
        run_frame("fresh", rand_frame(), 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
